// File: rtl/branch_pkg.sv
// branch_pkg: shared control-flow types for the branch unit, PC and decoder.
//   br_kind_e : branch encoding driven to the PC (same encoding as the decoded op).
//   state_e   : RUN/HALT state of the branch unit.
//   is_taken  : whether a RUN-state control op redirects, given the condition flag.
package branch_pkg;

   typedef enum logic [1:0] {
      BR_NONE   = 2'b00,
      BR_IF_T   = 2'b01,
      BR_IF_F   = 2'b10,
      BR_ALWAYS = 2'b11
   } br_kind_e;

   typedef enum logic {
      S_RUN  = 1'b0,
      S_HALT = 1'b1
   } state_e;

   function automatic logic is_taken(input logic [1:0] kind, input logic flag);
      logic t;
      t = 1'b0;
      unique case (kind)
         BR_ALWAYS: t = 1'b1;
         BR_IF_T:   t = flag;
         BR_IF_F:   t = ~flag;
         default:   t = 1'b0;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/branch_lut.sv
// branch_lut: 2^L x D jump-target register file.
//   One synchronous write port (we/waddr/wdata) and one combinational read port
//   (raddr/rdata). A same-cycle write and read of one entry returns the old value.
//   Ports: clk, reset (sync, active-high, clears all entries), we, waddr, wdata,
//          raddr, rdata.
module branch_lut #(
   parameter int unsigned D = 12,
   parameter int unsigned L = 5
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         we,
   input  logic [L-1:0] waddr,
   input  logic [D-1:0] wdata,
   input  logic [L-1:0] raddr,
   output logic [D-1:0] rdata
);

   localparam int unsigned Entries = 2 ** L;

   logic [D-1:0] mem_q [Entries];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < Entries; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/branch_unit.sv
// branch_unit: control-flow stage feeding the program counter.
//   Drives branch/target/jcnd to the PC every cycle, owns the RUN/HALT machine
//   (HALT freezes the PC on the captured halt address and raises done) and counts
//   taken redirects in a saturating counter.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   prog_ctr        current PC fed back from the PC
//   op_kind         decoded control op (br_kind_e encoding)
//   lut_idx         jump-target LUT entry of the current instruction
//   halt_req        current instruction is HALT
//   flag_we/flag_in condition flag write from the ALU
//   lut_we/lut_waddr/lut_wdata  LUT write port
//   rel             (BRANCH_UNIT_REL_EN only) target = prog_ctr + LUT entry
//   branch/target/jcnd  to the PC
//   done            high while halted
//   taken_cnt       saturating count of taken redirects
// Build option: define BRANCH_UNIT_REL_EN to add the rel port and PC-relative targets.
module branch_unit
   import branch_pkg::*;
#(
   parameter int unsigned D  = 12,
   parameter int unsigned L  = 5,
   parameter int unsigned CW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [D-1:0]  prog_ctr,
   input  logic [1:0]    op_kind,
   input  logic [L-1:0]  lut_idx,
   input  logic          halt_req,
   input  logic          flag_we,
   input  logic          flag_in,
   input  logic          lut_we,
   input  logic [L-1:0]  lut_waddr,
   input  logic [D-1:0]  lut_wdata,
`ifdef BRANCH_UNIT_REL_EN
   input  logic          rel,
`endif
   output logic [1:0]    branch,
   output logic [D-1:0]  target,
   output logic          jcnd,
   output logic          done,
   output logic [CW-1:0] taken_cnt
);

   state_e        state_q, state_d;
   logic          flag_q;
   logic [D-1:0]  halt_pc_q;
   logic [CW-1:0] cnt_q;
   logic          taken;
   logic [D-1:0]  lut_rdata;
   logic [D-1:0]  run_target;

   branch_lut #(
      .D(D),
      .L(L)
   ) u_lut (
      .clk   (clk),
      .reset (reset),
      .we    (lut_we),
      .waddr (lut_waddr),
      .wdata (lut_wdata),
      .raddr (lut_idx),
      .rdata (lut_rdata)
   );

`ifdef BRANCH_UNIT_REL_EN
   // LUT entry is a two's-complement offset in relative mode; the sum wraps mod 2^D.
   assign run_target = rel ? (prog_ctr + lut_rdata) : lut_rdata;
`else
   assign run_target = lut_rdata;
`endif

   always_comb begin
      state_d = state_q;
      branch  = BR_NONE;
      target  = '0;
      jcnd    = flag_q;
      done    = (state_q == S_HALT);
      taken   = 1'b0;
      if (reset) begin
         branch = BR_NONE;
         target = '0;
         jcnd   = 1'b0;
      end else begin
         unique case (state_q)
            S_RUN: begin
               if (halt_req) begin
                  // PC reloads its own value; halt wins over any op.
                  branch  = BR_ALWAYS;
                  target  = prog_ctr;
                  state_d = S_HALT;
               end else begin
                  branch = op_kind;
                  target = run_target;
                  taken  = is_taken(op_kind, flag_q);
               end
            end
            S_HALT: begin
               branch = BR_ALWAYS;
               target = halt_pc_q;
            end
            default: begin
               state_d = S_RUN;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_RUN;
         flag_q    <= 1'b0;
         halt_pc_q <= '0;
         cnt_q     <= '0;
      end else begin
         state_q <= state_d;
         if (flag_we) begin
            flag_q <= flag_in;
         end
         if (state_q == S_RUN && halt_req) begin
            halt_pc_q <= prog_ctr;
         end
         if (taken && (cnt_q != {CW{1'b1}})) begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

   assign taken_cnt = cnt_q;

endmodule

// File: tb/tb_branch_unit.sv
// tb_branch_unit: randomized + directed bench for branch_unit with a behavioural
// model checked every cycle, plus literal expectations on directed sequences.
module tb_branch_unit;

   localparam int unsigned D  = 12;
   localparam int unsigned L  = 5;
   localparam int unsigned CW = 4;
   localparam int unsigned CntMax = (1 << CW) - 1;

   logic          clk;
   logic          reset;
   logic [D-1:0]  prog_ctr;
   logic [1:0]    op_kind;
   logic [L-1:0]  lut_idx;
   logic          halt_req;
   logic          flag_we;
   logic          flag_in;
   logic          lut_we;
   logic [L-1:0]  lut_waddr;
   logic [D-1:0]  lut_wdata;
`ifdef BRANCH_UNIT_REL_EN
   logic          rel;
`endif
   logic [1:0]    branch;
   logic [D-1:0]  target;
   logic          jcnd;
   logic          done;
   logic [CW-1:0] taken_cnt;

   int n_cmp = 0;
   int n_err = 0;

   // Behavioural model state
   int unsigned m_lut [2**L];
   bit          m_flag;
   bit          m_halted;
   int unsigned m_hpc;
   int unsigned m_cnt;

   branch_unit #(
      .D  (D),
      .L  (L),
      .CW (CW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .prog_ctr  (prog_ctr),
      .op_kind   (op_kind),
      .lut_idx   (lut_idx),
      .halt_req  (halt_req),
      .flag_we   (flag_we),
      .flag_in   (flag_in),
      .lut_we    (lut_we),
      .lut_waddr (lut_waddr),
      .lut_wdata (lut_wdata),
`ifdef BRANCH_UNIT_REL_EN
      .rel       (rel),
`endif
      .branch    (branch),
      .target    (target),
      .jcnd      (jcnd),
      .done      (done),
      .taken_cnt (taken_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h, required %0h", name, $time, act, exp);
      end
   endtask

   // Compare process: mid-cycle, check outputs against the model, then advance the
   // model by what the coming clock edge will do.
   always @(negedge clk) begin
      int unsigned e_br, e_tgt, e_jc, e_done, lut_v;
      bit tk;
      lut_v = m_lut[lut_idx];
      if (reset) begin
         e_br = 0; e_tgt = 0; e_jc = 0; e_done = m_halted;
      end else if (m_halted) begin
         e_br = 3; e_tgt = m_hpc; e_jc = m_flag; e_done = 1;
      end else if (halt_req) begin
         e_br = 3; e_tgt = prog_ctr; e_jc = m_flag; e_done = 0;
      end else begin
         e_br = op_kind; e_tgt = lut_v; e_jc = m_flag; e_done = 0;
`ifdef BRANCH_UNIT_REL_EN
         if (rel) e_tgt = (prog_ctr + lut_v) % (1 << D);
`endif
      end
      check("m_branch", 32'(branch), e_br);
      check("m_target", 32'(target), e_tgt);
      check("m_jcnd", 32'(jcnd), e_jc);
      check("m_done", 32'(done), e_done);
      check("m_taken_cnt", 32'(taken_cnt), m_cnt);

      if (reset) begin
         foreach (m_lut[i]) m_lut[i] = 0;
         m_flag = 0; m_halted = 0; m_hpc = 0; m_cnt = 0;
      end else begin
         tk = !m_halted && !halt_req &&
              (op_kind == 2'b11 || (op_kind == 2'b01 && m_flag) || (op_kind == 2'b10 && !m_flag));
         if (tk && m_cnt < CntMax) m_cnt++;
         if (!m_halted && halt_req) begin
            m_halted = 1;
            m_hpc = prog_ctr;
         end
         if (flag_we) m_flag = flag_in;
         if (lut_we) m_lut[lut_waddr] = lut_wdata;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      op_kind = 2'b00; lut_idx = '0; halt_req = 1'b0; flag_we = 1'b0; flag_in = 1'b0;
      lut_we = 1'b0; lut_waddr = '0; lut_wdata = '0; prog_ctr = '0;
`ifdef BRANCH_UNIT_REL_EN
      rel = 1'b0;
`endif
   endtask

   initial begin
      foreach (m_lut[i]) m_lut[i] = 0;
      m_flag = 0; m_halted = 0; m_hpc = 0; m_cnt = 0;
      reset = 1'b1;
      idle_inputs();
      tick();
      tick();
      #1;
      check("rst_branch", 32'(branch), 0);
      check("rst_target", 32'(target), 0);
      check("rst_jcnd", 32'(jcnd), 0);
      reset = 1'b0;

      // Idle after reset
      for (int i = 0; i < 3; i++) begin
         #1;
         check("idle_branch", 32'(branch), 0);
         check("idle_jcnd", 32'(jcnd), 0);
         check("idle_done", 32'(done), 0);
         check("idle_cnt", 32'(taken_cnt), 0);
         tick();
      end

      // LUT write + flag set, then conditional branches
      lut_we = 1'b1; lut_waddr = 5'd3; lut_wdata = 12'h0A5; flag_we = 1'b1; flag_in = 1'b1;
      tick();
      lut_we = 1'b0; flag_we = 1'b0; op_kind = 2'b01; lut_idx = 5'd3;
      #1;
      check("bt_branch", 32'(branch), 1);
      check("bt_target", 32'(target), 32'h0A5);
      check("bt_jcnd", 32'(jcnd), 1);
      tick();
      op_kind = 2'b10;
      #1;
      check("bt_cnt", 32'(taken_cnt), 1);
      check("bf_branch", 32'(branch), 2);
      tick();
      op_kind = 2'b00;
      #1;
      check("bf_cnt", 32'(taken_cnt), 1);

      // Flag no-bypass
      flag_we = 1'b1; flag_in = 1'b0;
      tick();
      flag_in = 1'b1; op_kind = 2'b01;
      #1;
      check("nb_jcnd_old", 32'(jcnd), 0);
      tick();
      flag_we = 1'b0; op_kind = 2'b00;
      #1;
      check("nb_jcnd_new", 32'(jcnd), 1);
      check("nb_cnt", 32'(taken_cnt), 1);

      // LUT write/read collision
      lut_we = 1'b1; lut_waddr = 5'd7; lut_wdata = 12'h010;
      tick();
      lut_wdata = 12'h020; lut_idx = 5'd7;
      #1;
      check("col_old", 32'(target), 32'h010);
      tick();
      lut_we = 1'b0;
      #1;
      check("col_new", 32'(target), 32'h020);

      // Halt
      prog_ctr = 12'h123; halt_req = 1'b1; op_kind = 2'b11;
      #1;
      check("h_branch", 32'(branch), 3);
      check("h_target", 32'(target), 32'h123);
      tick();
      for (int i = 0; i < 10; i++) begin
         op_kind = 2'($urandom_range(0, 3));
         halt_req = 1'($urandom_range(0, 1));
         prog_ctr = 12'($urandom);
         #1;
         check("h_done", 32'(done), 1);
         check("h_hold_target", 32'(target), 32'h123);
         check("h_hold_branch", 32'(branch), 3);
         check("h_cnt", 32'(taken_cnt), 1);
         tick();
      end
      idle_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      check("h_reset_done", 32'(done), 0);
      check("h_reset_cnt", 32'(taken_cnt), 0);

      // Saturation
      op_kind = 2'b11;
      for (int i = 0; i < 20; i++) tick();
      op_kind = 2'b00;
      #1;
      check("sat_cnt", 32'(taken_cnt), 15);

`ifdef BRANCH_UNIT_REL_EN
      lut_we = 1'b1; lut_waddr = 5'd4; lut_wdata = 12'h005;
      tick();
      lut_we = 1'b0; rel = 1'b1; prog_ctr = 12'hFFE; lut_idx = 5'd4; op_kind = 2'b11;
      #1;
      check("rel_wrap", 32'(target), 32'h003);
      tick();
      idle_inputs();
`endif

      // Randomized phase
      for (int i = 0; i < 3000; i++) begin
         reset     = m_halted ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 99) == 0);
         halt_req  = ($urandom_range(0, 79) == 0);
         op_kind   = 2'($urandom_range(0, 3));
         lut_idx   = 5'($urandom_range(0, 7));
         flag_we   = ($urandom_range(0, 2) == 0);
         flag_in   = 1'($urandom);
         lut_we    = ($urandom_range(0, 2) == 0);
         lut_waddr = 5'($urandom_range(0, 7));
         lut_wdata = 12'($urandom);
         prog_ctr  = 12'($urandom);
`ifdef BRANCH_UNIT_REL_EN
         rel       = 1'($urandom);
`endif
         tick();
      end

      idle_inputs();
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
